// File: rtl/rr_ring_arbiter_pkg.sv
// Shared types and helpers for the round-robin ring arbiter.
// Helpers work on MAX_N-wide vectors so one definition serves any N up to MAX_N.
package ring_arb_pkg;

  localparam int MAX_N = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // One-hot rotate left by one within an n-bit ring (bit n-1 wraps to bit 0).
  function automatic logic [MAX_N-1:0] rot_left1(input logic [MAX_N-1:0] onehot,
                                                 input int n);
    logic [MAX_N-1:0] r;
    int j;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        j = (i + 1 == n) ? 0 : i + 1;
        r[j] = onehot[i];
      end
    end
    return r;
  endfunction

  // First set req bit scanning circularly upward from the ptr position; zero if none.
  function automatic logic [MAX_N-1:0] rr_pick(input logic [MAX_N-1:0] req,
                                               input logic [MAX_N-1:0] ptr,
                                               input int n);
    logic [MAX_N-1:0] r;
    logic found;
    int p;
    int idx;
    r     = '0;
    found = 1'b0;
    p     = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n && ptr[i]) p = i;
    end
    for (int k = 0; k < MAX_N; k++) begin
      if (k < n && !found) begin
        idx = p + k;
        if (idx >= n) idx = idx - n;
        if (req[idx]) begin
          r[idx] = 1'b1;
          found  = 1'b1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_ring_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Handshake: a requester holds req high as a level while it wants the resource; it owns the
// resource exactly while its gnt bit is high, and releases it by dropping req.
interface rr_ring_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         busy;
  logic [N-1:0] ptr;
  logic         timeout;

  modport master (
    output req,
    input  gnt,
    input  busy,
    input  ptr,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output busy,
    output ptr,
    output timeout
  );
endinterface

// File: rtl/rr_ring_arbiter_ptr.sv
// One-hot ring pointer: resets to bit 0, loads the winner rotated left by one on en.
module onehot_ring_ptr
  import ring_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] winner,
  output logic [N-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= N'(1);
    end else if (en) begin
      ptr <= N'(rot_left1(MAX_N'(winner), N));
    end
  end

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with one-hot rotating priority and a per-tenure hold limit.
// Every tenure ends with at least one IDLE cycle before the next grant.
module rr_ring_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_ring_arbiter_if.slave    bus,
  output arb_state_t          dbg_state
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  arb_state_t    state_q, state_nxt;
  logic [N-1:0]  gnt_q, gnt_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          timeout_q, timeout_nxt;
  logic          busy_q;
  logic          ptr_en;
  logic [N-1:0]  ptr;
  logic          owner_req;

  assign owner_req = |(bus.req & gnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      gnt_q     <= gnt_nxt;
      cnt_q     <= cnt_nxt;
      timeout_q <= timeout_nxt;
      busy_q    <= |gnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    gnt_nxt     = gnt_q;
    cnt_nxt     = cnt_q;
    timeout_nxt = 1'b0;
    ptr_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_nxt   = N'(rr_pick(MAX_N'(bus.req), MAX_N'(ptr), N));
          cnt_nxt   = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        // Release is checked first so it wins over a coincident hold-limit expiry.
        if (!owner_req) begin
          gnt_nxt   = '0;
          ptr_en    = 1'b1;
          state_nxt = IDLE;
        end else if (cnt_q == CW'(MAX_HOLD - 1)) begin
          gnt_nxt     = '0;
          ptr_en      = 1'b1;
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else if (cnt_q != CW'(MAX_HOLD)) begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  onehot_ring_ptr #(.N(N)) u_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (ptr_en),
    .winner (gnt_q),
    .ptr    (ptr)
  );

  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.ptr     = ptr;
  assign bus.timeout = timeout_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Directed bench for rr_ring_arbiter (N=4, MAX_HOLD=8) with hand-computed expectations.
module tb_rr_ring_arbiter;
  import ring_arb_pkg::*;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  arb_state_t dbg_state;
  int         n_checks;
  int         n_errors;

  rr_ring_arbiter_if #(.N(N)) bus ();

  rr_ring_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic b,
                           input logic [3:0] p, input logic t);
    check({tag, ".gnt"},     32'(bus.gnt), 32'(g));
    check({tag, ".busy"},    32'(bus.busy), 32'(b));
    check({tag, ".ptr"},     32'(bus.ptr), 32'(p));
    check({tag, ".timeout"}, 32'(bus.timeout), 32'(t));
  endtask

  logic [3:0] tenure_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] tenure_ptr [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] after_ptr  [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    bus.req  = '0;
    repeat (2) step();
    check_out("in_reset", 4'b0000, 1'b0, 4'b0001, 1'b0);
    check("in_reset.state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;

    // Idle with no requests
    for (int c = 0; c < 5; c++) begin
      step();
      check_out("idle", 4'b0000, 1'b0, 4'b0001, 1'b0);
    end

    // All four requesting: full hold-limited rotation
    bus.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        step();
        check_out($sformatf("rot%0d.c%0d", t, c), tenure_gnt[t], 1'b1, tenure_ptr[t], 1'b0);
        check($sformatf("rot%0d.c%0d.state", t, c), 32'(dbg_state), 32'(GRANT));
      end
      step();
      if (t == 4) bus.req = 4'b0000;
      check_out($sformatf("rot%0d.gap", t), 4'b0000, 1'b0, after_ptr[t], 1'b1);
    end
    step();
    check_out("rot.quiet", 4'b0000, 1'b0, 4'b0010, 1'b0);

    // Single requester releases after 3 cycles
    bus.req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step();
      check_out($sformatf("rel.c%0d", c), 4'b0100, 1'b1, 4'b0010, 1'b0);
    end
    bus.req = 4'b0000;
    step();
    check_out("rel.done", 4'b0000, 1'b0, 4'b1000, 1'b0);

    // Circular wrap from ptr=1000
    bus.req = 4'b0011;
    step();
    check_out("wrap.gnt", 4'b0001, 1'b1, 4'b1000, 1'b0);
    bus.req = 4'b0000;
    step();
    check_out("wrap.done", 4'b0000, 1'b0, 4'b0010, 1'b0);

    // Release in the last allowed cycle beats the timeout
    bus.req = 4'b0001;
    for (int c = 0; c < MAX_HOLD; c++) begin
      step();
      check_out($sformatf("edge.c%0d", c), 4'b0001, 1'b1, 4'b0010, 1'b0);
    end
    bus.req = 4'b0000;
    step();
    check_out("edge.done", 4'b0000, 1'b0, 4'b0010, 1'b0);
    check("edge.state", 32'(dbg_state), 32'(IDLE));

    // Asynchronous reset during a grant
    bus.req = 4'b0100;
    repeat (2) step();
    check_out("arst.pre", 4'b0100, 1'b1, 4'b0010, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_out("arst.during", 4'b0000, 1'b0, 4'b0001, 1'b0);
    bus.req = 4'b1111;
    step();
    check_out("arst.held", 4'b0000, 1'b0, 4'b0001, 1'b0);
    rst_n = 1'b1;
    step();
    check_out("arst.restart", 4'b0001, 1'b1, 4'b0001, 1'b0);
    bus.req = 4'b0000;
    step();
    check_out("arst.done", 4'b0000, 1'b0, 4'b0010, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
